param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 The block SHALL expose parameter DEPTH, default 16, number of entries (power of two, >=2).
REQ-003 The block SHALL expose parameter AF_LEVEL, default DEPTH-2, almost-full threshold in entries.
REQ-004 The block SHALL expose parameter AE_LEVEL, default 2, almost-empty threshold in entries.
REQ-005 The block SHALL expose parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have one clock and an asynchronous active-high reset: clk input 1, rising-edge clock; rst input 1, async active-high reset.
REQ-007 Data ports SHALL be: wr_en input 1; wr_data input DATA_W; rd_en input 1; rd_data output DATA_W; rd_valid output 1.
REQ-008 Status ports SHALL be: full, empty, almost_full, almost_empty output 1 each; level output $clog2(DEPTH)+1, current occupancy.
REQ-009 Error ports SHALL be: overflow output 1, sticky; underflow output 1, sticky; clr_err input 1, clears both sticky flags.

Function
REQ-010 A write SHALL be accepted on a clk edge iff wr_en=1 and full=0; accepted data is stored at the write pointer, which then increments.
REQ-011 A read SHALL be accepted on a clk edge iff rd_en=1 and empty=0; the read pointer then increments.
REQ-012 Pointers SHALL be $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; the address uses the low bits and the MSB distinguishes full from empty.
REQ-013 level SHALL equal wr_ptr-rd_ptr (modulo 2*DEPTH), range 0..DEPTH.
REQ-014 Simultaneous accepted read and write SHALL leave level unchanged; a write while full SHALL be rejected even if a read is accepted in the same cycle.
REQ-015 Flags SHALL derive from registered pointers only: empty = (level==0); full = (level==DEPTH); almost_full = (level>=AF_LEVEL); almost_empty = (level<=AE_LEVEL).
REQ-016 FWFT=0: an accepted read SHALL load rd_data from the head entry at that edge, and rd_valid SHALL be 1 for exactly the following cycle; rd_data holds its value otherwise.
REQ-017 FWFT=1: rd_data SHALL present the head entry combinationally from storage, rd_valid SHALL equal !empty, and an accepted read pops that entry.
REQ-018 FWFT=1: a write into an empty FIFO SHALL appear on rd_data with rd_valid=1 one cycle after the write edge.
REQ-019 overflow SHALL set on any edge with wr_en=1 and full=1; underflow SHALL set on any edge with rd_en=1 and empty=1.
REQ-020 clr_err=1 SHALL clear both sticky flags at the edge; a new error event on the same edge SHALL take priority and set the flag.
REQ-021 Rejected writes and reads SHALL not alter storage, pointers or rd_data.

Reset
REQ-022 While rst=1, pointers, level, rd_valid, rd_data, overflow and underflow SHALL be 0; empty=1, almost_empty=1, full=0, and almost_full=(AF_LEVEL==0).
REQ-023 Reset asserted mid-operation SHALL discard all contents immediately, asynchronously to clk.
REQ-024 Storage contents SHALL NOT be reset.

Structure
REQ-025 A shared package fifo_pkg SHALL hold the default constants for DATA_W, DEPTH and the thresholds, and the pointer-width function.
REQ-026 Storage SHALL be the sub-module fifo_mem: a DEPTH x DATA_W register array with synchronous write and asynchronous read.
REQ-027 Elaboration SHALL fail for non-power-of-two DEPTH or for AF_LEVEL/AE_LEVEL greater than DEPTH.

Verification
REQ-028 DEPTH=16, FWFT=0: write 0x01..0x10 on consecutive cycles -> full=1 after the 16th write, level=16, almost_full=1 from level 14.
REQ-029 Full FIFO: wr_en=1 with 0xAA -> write rejected, overflow=1, level stays 16; then clr_err=1 -> overflow=0.
REQ-030 From the REQ-028 fill, read 16 times -> rd_data 0x01..0x10 in order, each with rd_valid one cycle after the accepted read; empty=1 at the end.
REQ-031 level=5: simultaneous write 0x33 and read -> level remains 5; 40 cycles of continuous write+read -> pointer wrap, data order preserved.
REQ-032 FWFT=1, empty: write 0x5C -> next cycle rd_data=0x5C, rd_valid=1; rd_en on empty -> underflow=1.
REQ-033 rst pulsed between edges with level=9 -> empty=1, level=0, rd_valid=0, overflow=0 immediately; the next write of 0x7E is read back first.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  // almost_full defaults to this many entries below DEPTH
  localparam int DEF_AF_MARGIN = 2;
  localparam int DEF_AE_LEVEL  = 2;
  localparam int DEF_FWFT      = 0;

  // Pointer width: address bits plus one wrap bit to tell full from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
module fifo_mem #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: store the word at the write address on an accepted write.
  // NOTE: the array is deliberately left out of reset; validity is tracked
  // by the pointers, and a reset here would turn the RAM into flops with
  // a reset tree for no functional benefit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with status flags, sticky error flags
// and a choice of registered or first-word-fall-through read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int AE_LEVEL = DEF_AE_LEVEL,
  parameter int FWFT     = DEF_FWFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int AW    = PTR_W - 1;

  localparam logic [PTR_W-1:0] DEPTH_L = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_L    = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_L    = PTR_W'(AE_LEVEL);

  // Reject illegal configurations at elaboration time.
  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_sync_fifo: AF_LEVEL must lie in 0..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_ae
    $error("param_sync_fifo: AE_LEVEL must lie in 0..DEPTH");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("param_sync_fifo: DATA_W must be >= 1");
  end

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  occ;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] head_data;

  // Occupancy and flags come only from the registered pointers.
  assign occ          = wr_ptr - rd_ptr;
  assign level        = occ;
  assign empty        = (occ == '0);
  assign full         = (occ == DEPTH_L);
  assign almost_full  = (occ >= AF_L);
  assign almost_empty = (occ <= AE_L);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (head_data)
  );

  // Pointer update: each advances only on an accepted transfer.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky error flags: a new event on the clearing edge wins over clr_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      else if (clr_err)   overflow  <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is visible whenever the FIFO holds data; zero otherwise.
    assign rd_data  = empty ? '0 : head_data;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    // Registered read: capture the head on an accepted read, pulse valid.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= head_data;
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench: a registered-read instance driven against a
// reference FIFO model plus a scoreboard, and a FWFT instance exercised
// with short directed sequences.
module tb_param_sync_fifo;

  localparam int DW = 8;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst;

  // Registered-read instance
  logic          wr_en0, rd_en0, clr_err0;
  logic [DW-1:0] wr_data0, rd_data0;
  logic          rd_valid0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]    level0;

  // FWFT instance
  logic          wr_en1, rd_en1, clr_err1;
  logic [DW-1:0] wr_data1, rd_data1;
  logic          rd_valid1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]    level1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state for the registered-read instance
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sbq[$];
  int            cnt;
  logic          ovf_m, unf_m;
  logic [DW-1:0] last_rd;

  always #5 clk = ~clk;

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_data(wr_data0),
    .rd_en(rd_en0), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .level(level0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err0)
  );

  param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .FWFT(1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1),
    .rd_en(rd_en1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .level(level1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_status0();
    check("level",        32'(level0), 32'(cnt));
    check("full",         32'(full0),  32'(cnt == DP));
    check("empty",        32'(empty0), 32'(cnt == 0));
    check("almost_full",  32'(af0),    32'(cnt >= DP - 2));
    check("almost_empty", 32'(ae0),    32'(cnt <= 2));
    check("overflow",     32'(ovf0),   32'(ovf_m));
    check("underflow",    32'(unf0),   32'(unf_m));
  endtask

  // One clock of the registered-read instance with full model checking.
  task automatic cycle0(input logic we, input logic [DW-1:0] wd,
                        input logic re, input logic clr);
    logic wacc, racc, was_full, was_empty;
    was_full  = (cnt == DP);
    was_empty = (cnt == 0);
    wacc = we && !was_full;
    racc = re && !was_empty;
    wr_en0 = we; wr_data0 = wd; rd_en0 = re; clr_err0 = clr;
    if (racc) sbq.push_back(mq.pop_front());
    if (wacc) mq.push_back(wd);
    cnt = cnt + int'(wacc) - int'(racc);
    ovf_m = (we && was_full)  ? 1'b1 : (clr ? 1'b0 : ovf_m);
    unf_m = (re && was_empty) ? 1'b1 : (clr ? 1'b0 : unf_m);
    @(posedge clk);
    #1;
    wr_en0 = 1'b0; rd_en0 = 1'b0; clr_err0 = 1'b0;
    check("rd_valid", 32'(rd_valid0), 32'(racc));
    if (racc) begin
      last_rd = sbq.pop_front();
      check("rd_data", 32'(rd_data0), 32'(last_rd));
    end else begin
      check("rd_hold", 32'(rd_data0), 32'(last_rd));
    end
    check_status0();
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 0; rd_en0 = 0; clr_err0 = 0; wr_data0 = '0;
    wr_en1 = 0; rd_en1 = 0; clr_err1 = 0; wr_data1 = '0;
    cnt = 0; ovf_m = 0; unf_m = 0; last_rd = '0;

    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_rd_valid", 32'(rd_valid0), 0);
    check("rst_rd_data",  32'(rd_data0),  0);
    check_status0();
    check("rst_fwft_valid", 32'(rd_valid1), 0);
    check("rst_fwft_empty", 32'(empty1), 1);
    #3 rst = 1'b0;

    // Fill with 0x01..0x10
    for (int i = 1; i <= DP; i++) cycle0(1'b1, DW'(i), 1'b0, 1'b0);
    // Write into full FIFO: rejected, overflow sticks, then cleared
    cycle0(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle0(1'b0, 8'h00, 1'b0, 1'b1);
    // Drain, expecting 0x01..0x10 in order
    for (int i = 0; i < DP; i++) cycle0(1'b0, 8'h00, 1'b1, 1'b0);
    // Underflow, then clr on the same edge as a new underflow keeps it set
    cycle0(1'b0, 8'h00, 1'b1, 1'b0);
    cycle0(1'b0, 8'h00, 1'b1, 1'b1);
    cycle0(1'b0, 8'h00, 1'b0, 1'b1);

    // Level 5, simultaneous write/read, then 40 cycles of streaming
    for (int i = 0; i < 5; i++) cycle0(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    cycle0(1'b1, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle0(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle0(1'b0, 8'h00, 1'b1, 1'b0);

    // Level 9 with a read in flight, then asynchronous reset between edges
    for (int i = 0; i < 9; i++) cycle0(1'b1, DW'(8'h90 + i), 1'b0, 1'b0);
    cycle0(1'b1, 8'h99, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_empty",    32'(empty0),    1);
    check("arst_level",    32'(level0),    0);
    check("arst_rd_valid", 32'(rd_valid0), 0);
    check("arst_rd_data",  32'(rd_data0),  0);
    check("arst_overflow", 32'(ovf0),      0);
    mq.delete(); sbq.delete();
    cnt = 0; ovf_m = 0; unf_m = 0; last_rd = '0;
    #2 rst = 1'b0;
    cycle0(1'b1, 8'h7E, 1'b0, 1'b0);
    cycle0(1'b1, 8'h11, 1'b0, 1'b0);
    cycle0(1'b0, 8'h00, 1'b1, 1'b0);
    cycle0(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT instance
    wr_en1 = 1'b1; wr_data1 = 8'h5C;
    @(posedge clk); #1;
    wr_en1 = 1'b0;
    check("fwft_data_5c",  32'(rd_data1),  32'h5C);
    check("fwft_valid",    32'(rd_valid1), 1);
    check("fwft_level1",   32'(level1),    1);
    wr_en1 = 1'b1; wr_data1 = 8'h6D;
    @(posedge clk); #1;
    wr_en1 = 1'b0;
    check("fwft_head_kept", 32'(rd_data1), 32'h5C);
    check("fwft_level2",    32'(level1),   2);
    rd_en1 = 1'b1;
    @(posedge clk); #1;
    check("fwft_data_6d", 32'(rd_data1),  32'h6D);
    check("fwft_valid2",  32'(rd_valid1), 1);
    @(posedge clk); #1;
    check("fwft_empty",     32'(empty1),    1);
    check("fwft_valid_off", 32'(rd_valid1), 0);
    check("fwft_no_unf",    32'(unf1),      0);
    @(posedge clk); #1;
    rd_en1 = 1'b0;
    check("fwft_underflow", 32'(unf1), 1);
    clr_err1 = 1'b1;
    @(posedge clk); #1;
    clr_err1 = 1'b0;
    check("fwft_unf_clr", 32'(unf1), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "time limit reached");
  end

endmodule
